// File: rtl/apb2reg_native_bridge.sv
// APB4 slave to reg_native_if bridge feeding the upstream port of regdisp_root_map.
// Each APB transfer becomes exactly one downstream request. Every output comes
// straight from a flop. A partial-strobe write is answered locally with an error.
// A downstream timeout guarantees that every accepted APB transfer completes.
module apb2reg_native_bridge #(
    parameter int                    ADDR_WIDTH      = 48,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    TIMEOUT_CYCLES  = 256,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_RD_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                    regdisp_root_map_clk,
    input  logic                    regdisp_root_map_rst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr,
    input  logic                    soft_rst_in,
    output logic                    upstream__regdisp_root_map__req_vld,
    output logic [ADDR_WIDTH-1:0]   upstream__regdisp_root_map__addr,
    output logic                    upstream__regdisp_root_map__wr_en,
    output logic                    upstream__regdisp_root_map__rd_en,
    output logic [DATA_WIDTH-1:0]   upstream__regdisp_root_map__wr_data,
    output logic                    upstream__regdisp_root_map__non_sec,
    output logic                    upstream__regdisp_root_map__soft_rst,
    input  logic                    regdisp_root_map__upstream__ack_vld,
    input  logic                    regdisp_root_map__upstream__err,
    input  logic [DATA_WIDTH-1:0]   regdisp_root_map__upstream__rd_data,
    output logic                    timeout_evt
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    // A zero timeout still needs a legal one-bit counter.
    localparam int CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [STRB_W-1:0] STRB_ALL = {STRB_W{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    is_write_q, is_write_d;
    logic                    req_vld_q, req_vld_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    non_sec_q, non_sec_d;
    logic                    pready_q, pready_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;
    logic                    timeout_evt_q, timeout_evt_d;
    logic                    soft_rst_q;

    logic                    setup_s;
    logic                    ack_s;
    logic [DATA_WIDTH-1:0]   ack_data_s;
    logic                    timed_out_s;
    logic                    unused_s;

    // Byte-lane bits below the word boundary and the other protection bits are not forwarded.
    assign unused_s = ^{paddr[LSB-1:0], pprot[2], pprot[0]};

    assign setup_s     = psel & ~penable;
    assign ack_s       = regdisp_root_map__upstream__ack_vld;
    assign ack_data_s  = is_write_q ? DATA_ZERO : regdisp_root_map__upstream__rd_data;
    assign timed_out_s = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);

    // Next-state and next-output logic; all request/response outputs default to idle values.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_write_d    = is_write_q;
        req_vld_d     = 1'b0;
        addr_d        = ADDR_ZERO;
        wr_en_d       = 1'b0;
        rd_en_d       = 1'b0;
        wr_data_d     = DATA_ZERO;
        non_sec_d     = 1'b0;
        pready_d      = 1'b0;
        prdata_d      = DATA_ZERO;
        pslverr_d     = 1'b0;
        timeout_evt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (setup_s) begin
                    is_write_d = pwrite;
                    if (pwrite && (pstrb != STRB_ALL)) begin
                        // Partial-strobe write: answer with an error, nothing goes downstream.
                        state_d   = ST_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        state_d   = ST_REQ;
                        req_vld_d = 1'b1;
                        addr_d    = {paddr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
                        wr_en_d   = pwrite;
                        rd_en_d   = ~pwrite;
                        wr_data_d = pwdata;
                        non_sec_d = pprot[1];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                cnt_d = CNT_ONE;
                if (ack_s) begin
                    state_d   = ST_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = regdisp_root_map__upstream__err;
                    prdata_d  = ack_data_s;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                // A response arriving in the same cycle as the timeout wins.
                if (ack_s) begin
                    state_d   = ST_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = regdisp_root_map__upstream__err;
                    prdata_d  = ack_data_s;
                end else if (timed_out_s) begin
                    state_d       = ST_RESP;
                    pready_d      = 1'b1;
                    pslverr_d     = 1'b1;
                    prdata_d      = is_write_q ? DATA_ZERO : TIMEOUT_RD_DATA;
                    timeout_evt_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and every registered output; async reset clears them all.
    always_ff @(posedge regdisp_root_map_clk or negedge regdisp_root_map_rst_n) begin
        if (!regdisp_root_map_rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            is_write_q    <= 1'b0;
            req_vld_q     <= 1'b0;
            addr_q        <= ADDR_ZERO;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            wr_data_q     <= DATA_ZERO;
            non_sec_q     <= 1'b0;
            pready_q      <= 1'b0;
            prdata_q      <= DATA_ZERO;
            pslverr_q     <= 1'b0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_write_q    <= is_write_d;
            req_vld_q     <= req_vld_d;
            addr_q        <= addr_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            wr_data_q     <= wr_data_d;
            non_sec_q     <= non_sec_d;
            pready_q      <= pready_d;
            prdata_q      <= prdata_d;
            pslverr_q     <= pslverr_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    // Soft-reset request is simply retimed by one stage, independent of transfer state.
    always_ff @(posedge regdisp_root_map_clk or negedge regdisp_root_map_rst_n) begin
        if (!regdisp_root_map_rst_n) begin
            soft_rst_q <= 1'b0;
        end else begin
            soft_rst_q <= soft_rst_in;
        end
    end

    assign pready                               = pready_q;
    assign prdata                               = prdata_q;
    assign pslverr                              = pslverr_q;
    assign upstream__regdisp_root_map__req_vld  = req_vld_q;
    assign upstream__regdisp_root_map__addr     = addr_q;
    assign upstream__regdisp_root_map__wr_en    = wr_en_q;
    assign upstream__regdisp_root_map__rd_en    = rd_en_q;
    assign upstream__regdisp_root_map__wr_data  = wr_data_q;
    assign upstream__regdisp_root_map__non_sec  = non_sec_q;
    assign upstream__regdisp_root_map__soft_rst = soft_rst_q;
    assign timeout_evt                          = timeout_evt_q;

endmodule

// File: tb/tb_apb2reg_native_bridge.sv
// Bench for apb2reg_native_bridge. Each transfer is described at the transaction
// level. The expected per-cycle outputs are worked out from latency rules: the
// request comes one cycle after setup, and the response comes one cycle after the
// earlier of the ack and the timeout. A compare process checks every cycle.
module tb_apb2reg_native_bridge;

    localparam int AW   = 48;
    localparam int DW   = 32;
    localparam int TO   = 4;
    localparam int NCYC = 400;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    pstrb = 4'h0;
    logic [2:0]    pprot = 3'b000;
    logic          pready, pslverr, soft_rst_in = 1'b0;
    logic [DW-1:0] prdata;
    logic          req_vld, wr_en, rd_en, non_sec, soft_rst, tevt;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          ack_vld = 1'b0, ack_err = 1'b0;
    logic [DW-1:0] ack_rdata = '0;

    apb2reg_native_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .regdisp_root_map_clk                 (clk),
        .regdisp_root_map_rst_n               (rst_n),
        .psel                                 (psel),
        .penable                              (penable),
        .pwrite                               (pwrite),
        .paddr                                (paddr),
        .pwdata                               (pwdata),
        .pstrb                                (pstrb),
        .pprot                                (pprot),
        .pready                               (pready),
        .prdata                               (prdata),
        .pslverr                              (pslverr),
        .soft_rst_in                          (soft_rst_in),
        .upstream__regdisp_root_map__req_vld  (req_vld),
        .upstream__regdisp_root_map__addr     (addr),
        .upstream__regdisp_root_map__wr_en    (wr_en),
        .upstream__regdisp_root_map__rd_en    (rd_en),
        .upstream__regdisp_root_map__wr_data  (wr_data),
        .upstream__regdisp_root_map__non_sec  (non_sec),
        .upstream__regdisp_root_map__soft_rst (soft_rst),
        .regdisp_root_map__upstream__ack_vld  (ack_vld),
        .regdisp_root_map__upstream__err      (ack_err),
        .regdisp_root_map__upstream__rd_data  (ack_rdata),
        .timeout_evt                          (tevt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;
    logic cmp_en = 1'b0;
    logic exp_srst = 1'b0;

    // Expected outputs per cycle (zero unless a transfer says otherwise).
    logic          e_req [NCYC], e_wr [NCYC], e_rd [NCYC], e_ns [NCYC];
    logic          e_rdy [NCYC], e_err [NCYC], e_tevt [NCYC];
    logic [AW-1:0] e_addr [NCYC];
    logic [DW-1:0] e_wd [NCYC], e_prd [NCYC];
    // What the DUT showed, for the literal spot checks.
    logic          l_req [NCYC], l_wr [NCYC], l_rd [NCYC], l_ns [NCYC];
    logic          l_rdy [NCYC], l_err [NCYC], l_tevt [NCYC];
    logic [AW-1:0] l_addr [NCYC];
    logic [DW-1:0] l_prd [NCYC];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void clear_from(input int c);
        for (int i = c; i < NCYC; i++) begin
            e_req[i] = 1'b0; e_wr[i] = 1'b0; e_rd[i] = 1'b0; e_ns[i] = 1'b0;
            e_rdy[i] = 1'b0; e_err[i] = 1'b0; e_tevt[i] = 1'b0;
            e_addr[i] = '0; e_wd[i] = '0; e_prd[i] = '0;
        end
    endfunction

    // Cycle counter: cycle c is the interval after the c-th rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Soft-reset output is the input seen at the previous edge.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) exp_srst = 1'b0;
        else        exp_srst = soft_rst_in;
    end

    // Compare every output against the expectation for the current cycle.
    initial forever begin
        @(negedge clk);
        if (cmp_en && cyc < NCYC) begin
            l_req[cyc] = req_vld; l_wr[cyc] = wr_en; l_rd[cyc] = rd_en; l_ns[cyc] = non_sec;
            l_rdy[cyc] = pready; l_err[cyc] = pslverr; l_tevt[cyc] = tevt;
            l_addr[cyc] = addr; l_prd[cyc] = prdata;
            chk("req_vld", 64'(req_vld), 64'(e_req[cyc]));
            chk("addr", 64'(addr), 64'(e_addr[cyc]));
            chk("wr_en", 64'(wr_en), 64'(e_wr[cyc]));
            chk("rd_en", 64'(rd_en), 64'(e_rd[cyc]));
            chk("wr_data", 64'(wr_data), 64'(e_wd[cyc]));
            chk("non_sec", 64'(non_sec), 64'(e_ns[cyc]));
            chk("pready", 64'(pready), 64'(e_rdy[cyc]));
            chk("prdata", 64'(prdata), 64'(e_prd[cyc]));
            chk("pslverr", 64'(pslverr), 64'(e_err[cyc]));
            chk("timeout_evt", 64'(tevt), 64'(e_tevt[cyc]));
            chk("soft_rst", 64'(soft_rst), 64'(exp_srst));
        end
    end

    // One APB transfer. d = ack offset from the request cycle (-1: never).
    // rst_at >= 0 aborts the transfer with a reset that many cycles after the request.
    task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [3:0] st, input logic [2:0] pr, input int d,
                       input logic aerr, input logic [DW-1:0] ard, input int rst_at,
                       output int req_c);
        int  c0, resp;
        logic partial;
        c0 = cyc;
        partial = wr && (st != 4'hF);
        req_c = c0 + 1;
        if (partial) begin
            resp = c0 + 1;
            e_rdy[resp] = 1'b1; e_err[resp] = 1'b1;
        end else begin
            e_req[req_c] = 1'b1;
            e_addr[req_c] = {a[AW-1:2], 2'b00};
            e_wr[req_c] = wr; e_rd[req_c] = !wr;
            e_wd[req_c] = wd; e_ns[req_c] = pr[1];
            if (d >= 0 && d <= TO) begin
                resp = req_c + d + 1;
                e_err[resp] = aerr;
                e_prd[resp] = wr ? 32'h0 : ard;
            end else begin
                resp = req_c + TO + 1;
                e_err[resp] = 1'b1;
                e_prd[resp] = wr ? 32'h0 : 32'hDEAD_BEEF;
                e_tevt[resp] = 1'b1;
            end
            e_rdy[resp] = 1'b1;
        end
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a;
        pwdata = wd; pstrb = st; pprot = pr;
        forever begin
            @(posedge clk); #1;
            penable = 1'b1;
            if (rst_at >= 0 && cyc == req_c + rst_at) begin
                clear_from(cyc);
                rst_n = 1'b0;
                psel = 1'b0; penable = 1'b0; ack_vld = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                break;
            end
            ack_vld   = (!partial && d >= 0 && cyc == req_c + d);
            ack_err   = ack_vld ? aerr : 1'b0;
            ack_rdata = ack_vld ? ard : 32'h0;
            if (cyc >= resp + 1) begin
                psel = 1'b0; penable = 1'b0;
                ack_vld = 1'b0; ack_err = 1'b0; ack_rdata = 32'h0;
                break;
            end
        end
    endtask

    initial begin
        int r, c, n;
        clear_from(0);
        @(posedge clk); #1;
        cmp_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Read, ack two cycles after the request.
        txn(1'b0, 48'h1006, 32'h0, 4'h0, 3'b000, 2, 1'b0, 32'h1234_5678, -1, r);
        chk("t1_addr", 64'(l_addr[r]), 64'h1004);
        chk("t1_rd_en", 64'(l_rd[r]), 64'd1);
        chk("t1_rd_en_once", 64'(l_rd[r+1]), 64'd0);
        chk("t1_pready", 64'(l_rdy[r+3]), 64'd1);
        chk("t1_prdata", 64'(l_prd[r+3]), 64'h1234_5678);
        chk("t1_pslverr", 64'(l_err[r+3]), 64'd0);

        // Write with same-cycle ack, back to back, soft reset toggled meanwhile.
        soft_rst_in = 1'b1;
        txn(1'b1, 48'h2000, 32'hA5A5_A5A5, 4'hF, 3'b010, 0, 1'b0, 32'h0, -1, r);
        soft_rst_in = 1'b0;
        chk("t2_wr_en", 64'(l_wr[r]), 64'd1);
        chk("t2_non_sec", 64'(l_ns[r]), 64'd1);
        chk("t2_pready", 64'(l_rdy[r+1]), 64'd1);
        chk("t2_prdata", 64'(l_prd[r+1]), 64'h0);

        // Partial strobe write: local error, nothing downstream.
        txn(1'b1, 48'h3000, 32'h1111_2222, 4'h3, 3'b000, -1, 1'b0, 32'h0, -1, r);
        c = r - 1;
        n = 0;
        for (int i = c; i <= c + 2; i++) n += int'(l_req[i]);
        chk("t3_no_req", 64'(n), 64'd0);
        chk("t3_pready", 64'(l_rdy[c+1]), 64'd1);
        chk("t3_pslverr", 64'(l_err[c+1]), 64'd1);

        // Read timeout.
        txn(1'b0, 48'h4008, 32'h0, 4'h0, 3'b000, -1, 1'b0, 32'h0, -1, r);
        chk("t4_pready", 64'(l_rdy[r+5]), 64'd1);
        chk("t4_prdata", 64'(l_prd[r+5]), 64'hDEAD_BEEF);
        chk("t4_pslverr", 64'(l_err[r+5]), 64'd1);
        n = 0;
        for (int i = r; i <= r + 6; i++) n += int'(l_tevt[i]);
        chk("t4_tevt_once", 64'(n), 64'd1);

        // Ack collides with timeout: ack wins.
        txn(1'b0, 48'h5000, 32'h0, 4'h0, 3'b000, 4, 1'b1, 32'hCAFE_0001, -1, r);
        chk("t5_pready", 64'(l_rdy[r+5]), 64'd1);
        chk("t5_prdata", 64'(l_prd[r+5]), 64'hCAFE_0001);
        chk("t5_pslverr", 64'(l_err[r+5]), 64'd1);
        chk("t5_no_tevt", 64'(l_tevt[r+5]), 64'd0);

        // Reset in WAIT, then a stray ack in IDLE, then a normal transfer.
        txn(1'b0, 48'h6000, 32'h0, 4'h0, 3'b000, -1, 1'b0, 32'h0, 2, r);
        chk("t6_rst_pready", 64'(l_rdy[r+2]), 64'd0);
        chk("t6_rst_req", 64'(l_req[r+2]), 64'd0);
        ack_vld = 1'b1; ack_rdata = 32'h7777_7777;
        c = cyc;
        @(posedge clk); #1;
        ack_vld = 1'b0; ack_rdata = 32'h0;
        @(posedge clk); #1;
        chk("t6_stray_pready", 64'(l_rdy[c+1]), 64'd0);
        txn(1'b0, 48'h7004, 32'h0, 4'h0, 3'b010, 1, 1'b0, 32'h0BAD_F00D, -1, r);
        chk("t6_next_prdata", 64'(l_prd[r+2]), 64'h0BAD_F00D);
        chk("t6_next_ns", 64'(l_ns[r]), 64'd1);

        repeat (3) begin @(posedge clk); #1; end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/apb2reg_native_bridge.md
Name: apb2reg_native_bridge

Overview:
- APB4 slave front-end that converts one APB transfer into one reg_native_if request and drives the upstream__regdisp_root_map__* port of regdisp_root_map.
- Sits between the SoC APB interconnect and the register dispatch tree.
- Registers every request and response, and guarantees APB completion through a downstream timeout.
- Rejects partial-strobe writes locally, without issuing a downstream request.

Parameters:
- ADDR_WIDTH, 48, APB and reg_native_if address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- TIMEOUT_CYCLES, 256, maximum cycles from req_vld to ack_vld; 0 disables the timeout.
- TIMEOUT_RD_DATA, 32'hDEAD_BEEF, prdata value returned on a timed-out read.

Ports:
- regdisp_root_map_clk  in  1  clock.
- regdisp_root_map_rst_n  in  1  asynchronous, active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB write.
- paddr  in  ADDR_WIDTH  APB byte address.
- pwdata  in  DATA_WIDTH  APB write data.
- pstrb  in  DATA_WIDTH/8  APB write strobes.
- pprot  in  3  APB protection; bit 1 = non-secure.
- pready  out  1  APB ready.
- prdata  out  DATA_WIDTH  APB read data.
- pslverr  out  1  APB error.
- soft_rst_in  in  1  software reset request, level.
- upstream__regdisp_root_map__req_vld  out  1  request pulse.
- upstream__regdisp_root_map__addr  out  ADDR_WIDTH  word-aligned address.
- upstream__regdisp_root_map__wr_en  out  1  write request.
- upstream__regdisp_root_map__rd_en  out  1  read request.
- upstream__regdisp_root_map__wr_data  out  DATA_WIDTH  write data.
- upstream__regdisp_root_map__non_sec  out  1  equals pprot[1].
- upstream__regdisp_root_map__soft_rst  out  1  soft_rst_in delayed by one register stage.
- regdisp_root_map__upstream__ack_vld  in  1  response valid.
- regdisp_root_map__upstream__err  in  1  response error; valid together with ack_vld.
- regdisp_root_map__upstream__rd_data  in  DATA_WIDTH  read data; valid together with ack_vld.
- timeout_evt  out  1  one-cycle pulse when a transfer times out.

Behaviour:
- Reset: all outputs are 0 and state = IDLE. Everything is registered; no combinational path from any input to any output.
- States: IDLE, REQ, WAIT, RESP.
- IDLE, on APB setup phase (psel=1, penable=0):
  - Capture addr = {paddr[ADDR_WIDTH-1:LSB], LSB'b0}, where LSB = log2(DATA_WIDTH/8).
  - Capture wr_en = pwrite, rd_en = !pwrite, wr_data = pwdata, non_sec = pprot[1].
  - If pwrite=1 and pstrb is not all-ones: go to RESP with err=1, prdata=0; no downstream request is issued.
  - Otherwise go to REQ.
- REQ (exactly 1 cycle):
  - req_vld, wr_en/rd_en, addr, wr_data, non_sec asserted; the timeout counter loads 1.
  - If ack_vld=1 in this cycle, capture the response and go to RESP; otherwise go to WAIT.
  - req_vld, wr_en and rd_en are 0 in every other state; addr, wr_data and non_sec return to 0 outside REQ.
- WAIT:
  - The counter increments each cycle.
  - ack_vld=1: capture pslverr = err and prdata = rd_data (reads) or 0 (writes), then go to RESP. ack takes priority over timeout in the same cycle.
  - Counter == TIMEOUT_CYCLES with no ack (and TIMEOUT_CYCLES != 0): pslverr=1, prdata = TIMEOUT_RD_DATA for reads or 0 for writes, pulse timeout_evt, go to RESP.
- RESP (exactly 1 cycle): pready=1 with prdata and pslverr valid; then go to IDLE. pready, prdata and pslverr are 0 in every other state.
- Latency: setup at T0, req_vld at T1, earliest pready at T2. A 3-cycle APB transfer is the minimum. Back-to-back: the next setup may appear in the cycle after RESP.
- Stray ack_vld in IDLE or RESP is ignored and does not change state. A late ack from a timed-out transfer that lands in a later WAIT is accepted as that transfer's response; this is a known limitation.
- psel/penable dropping mid-transfer (protocol violation): the transfer still completes and pready pulses once.
- Counter saturates and never wraps. Its width is clog2(TIMEOUT_CYCLES+1).
- soft_rst: the output register follows soft_rst_in in every state. It is reset to 0 by regdisp_root_map_rst_n only.
- Asynchronous reset mid-transfer returns to IDLE with all outputs 0. No pready is issued for the aborted transfer.

Test Plan:
- Read, ack in WAIT: paddr=0x1006, read; ack_vld 2 cycles after req_vld with rd_data=0x12345678 -> addr=0x1004, rd_en=1 for 1 cycle, pready at req+3 with prdata=0x12345678, pslverr=0.
- Write, same-cycle ack: pwdata=0xA5A5A5A5, pstrb=4'hF, pprot=3'b010; ack_vld in the REQ cycle -> wr_en=1, non_sec=1, pready at T2, prdata=0, pslverr=0.
- Partial strobe: write with pstrb=4'h3 -> no req_vld ever; pready at T1 with pslverr=1.
- Timeout: TIMEOUT_CYCLES=4, read with no ack -> pready 5 cycles after req_vld, pslverr=1, prdata=0xDEADBEEF, timeout_evt pulses once.
- Ack/timeout collision: TIMEOUT_CYCLES=4, ack arrives at counter==4 with err=1 -> response taken from ack (pslverr=1, prdata = rd_data), timeout_evt stays 0.
- Reset in WAIT, then a stray ack in IDLE: assert rst_n=0 during WAIT -> all outputs 0, state IDLE; a following stray ack_vld leaves pready=0, and the next transfer completes normally.
